lift_call_scheduler: RTL and testbench
======================================

Name: lift_call_scheduler

Overview:
- Call scheduler and motion sequencer for a single lift car serving FLOORS floors.
- Latches hall and car call requests into a pending set.
- Picks the travel direction using SCAN: keep going while calls lie ahead, then reverse.
- Times floor-to-floor travel and door dwell; drives the car-level motion and door signals consumed by the lift FSM benchmark family.

Parameters:
- FLOORS, 8, number of served floors (2..16).
- FLOOR_W, 3, width of floor index, ceil(log2(FLOORS)).
- TRAVEL_CYC, 4, cycles to travel one floor (>=1).
- DOOR_CYC, 6, cycles the door stays open (>=1).

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- call_req  in  FLOORS  bit i high for one or more cycles requests floor i.
- estop  in  1  emergency stop, level sensitive.
- call_pending  out  FLOORS  registered pending-call set.
- cur_floor  out  FLOOR_W  registered current floor.
- dir_up  out  1  1 = up, 0 = down; registered.
- moving  out  1  high in MOVE.
- door_open  out  1  high in DOOR.
- arrive  out  1  one-cycle pulse on the cycle DOOR is entered.
- idle  out  1  high in IDLE.
- keyinput  in  14  lock key; present only with LIFT_SCHED_LOCK_EN.

Behaviour:
- Reset: state=IDLE, call_pending=0, cur_floor=0, dir_up=1, moving=0, door_open=0, arrive=0, idle=1, timers=0.
- Pending set: pending |= call_req every cycle, except in STOP.
- Entering DOOR clears the bit for cur_floor.
- A call for cur_floor while in DOOR is absorbed (bit stays 0) and restarts the door timer.
- Request bits for floors >= FLOORS do not exist; width equals FLOORS.
- States IDLE, MOVE, DOOR, STOP; estop has priority over all transitions.
- IDLE:
  - pending[cur_floor] -> DOOR next cycle.
  - Else any pending ahead in dir_up -> MOVE.
  - Else any pending behind -> toggle dir_up, then MOVE.
  - Else stay in IDLE.
- MOVE:
  - Travel timer counts 0..TRAVEL_CYC-1.
  - At terminal count, cur_floor steps by +/-1.
  - Then: if pending[new floor], go DOOR; else if calls still ahead, stay in MOVE with the timer cleared; else IDLE.
  - cur_floor never wraps; floor 0 and floor FLOORS-1 are hard limits. Reaching a limit with no call there forces IDLE.
- DOOR:
  - Dwell timer counts 0..DOOR_CYC-1, then IDLE.
  - Direction is re-evaluated in IDLE.
- STOP:
  - Entered from any state while estop=1.
  - moving=0, door_open=0; timers cleared; cur_floor and dir_up held; pending held; new calls ignored.
  - estop=0 -> IDLE. A partial travel is discarded and the floor is unchanged.
- Latency: call at an idle car's floor -> door_open 2 cycles after call_req assertion (1 cycle latch, 1 cycle transition).
- Simultaneous events: the call merge and the clear of cur_floor on DOOR entry fall in the same cycle; the clear wins.

Optional Feature:
- LIFT_SCHED_LOCK_EN: time-windowed key lock.
- Adds the keyinput port and a 6-bit window counter.
  - Counter cycles 0..43 and is cleared by rst.
  - Windows are 0-10, 11-21, 22-32, 33-43, with keys 4765, 3070, 12731, 5960 respectively.
- Key mismatch in the current window: next state is forced to the window decoy (IDLE, MOVE, DOOR, STOP respectively) instead of the computed next state. Datapath updates follow the forced state.
- Without the macro: no keyinput port, no counter; normal behaviour only.

Decomposition:
- Package lift_sched_pkg holds:
  - state enum constants IDLE=0, MOVE=1, DOOR=2, STOP=3;
  - the four key constants;
  - the window bounds 10/21/32/43.
- One natural sub-module, lift_sched_dir: combinational pending_above/pending_below from call_pending and cur_floor.

Test Plan:
- Reset, then call_req[0] pulse at floor 0 -> arrive pulse and door_open after 2 cycles; door_open high 6 cycles; then idle=1, call_pending=0.
- From floor 0, call_req[3] -> moving for 12 cycles, cur_floor 1,2,3, door_open at floor 3, pending[3] cleared.
- At floor 3 moving up with pending {5,1} -> serves 5 first, then dir_up=0, serves 1; verifies no overshoot past floor 5.
- estop asserted mid-travel floor 2->3 for 5 cycles -> STOP, cur_floor stays 2, pending retained, calls during estop dropped; after release travel restarts with a full 4-cycle count.
- Call for cur_floor during DOOR at cycle 4 of 6 -> dwell restarts, total open 11 cycles, pending bit stays 0.
- With LIFT_SCHED_LOCK_EN: correct keys per window -> identical trace to the unlocked run; keyinput=0 in window 1 -> state forced to MOVE, observed output trace differs from the golden run.

Source files
------------

// File: rtl/lift_sched_pkg.sv
// Purpose : shared state encoding, lock keys and lock window bounds for the lift call scheduler.
// Latency : n/a (constants and types only).
// Backpressure: n/a.
package lift_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2,
        STOP = 2'd3
    } state_t;

    // Lock keys, one per window of the 44-cycle lock period.
    localparam logic [13:0] KEY_W0 = 14'd4765;
    localparam logic [13:0] KEY_W1 = 14'd3070;
    localparam logic [13:0] KEY_W2 = 14'd12731;
    localparam logic [13:0] KEY_W3 = 14'd5960;

    // Last count value (inclusive) of each lock window.
    localparam logic [5:0] WIN0_END = 6'd10;
    localparam logic [5:0] WIN1_END = 6'd21;
    localparam logic [5:0] WIN2_END = 6'd32;
    localparam logic [5:0] WIN3_END = 6'd43;

endpackage

// File: rtl/lift_sched_dir.sv
// Purpose : flags whether any pending call lies above or below the current floor.
// Latency : combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports   : call_pending (pending set), cur_floor (car position) -> pending_above, pending_below.
module lift_sched_dir
    import lift_sched_pkg::*;
#(
    parameter int FLOORS  = 8,
    parameter int FLOOR_W = 3
) (
    input  logic [FLOORS-1:0]  call_pending,
    input  logic [FLOOR_W-1:0] cur_floor,
    output logic               pending_above,
    output logic               pending_below
);

    always_comb begin
        pending_above = 1'b0;
        pending_below = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (call_pending[i] && (FLOOR_W'(i) > cur_floor)) pending_above = 1'b1;
            if (call_pending[i] && (FLOOR_W'(i) < cur_floor)) pending_below = 1'b1;
        end
    end

endmodule

// File: rtl/lift_call_scheduler.sv
// Purpose : SCAN call scheduler and motion/door sequencer for one lift car.
// Latency : call at an idle car's floor opens the door 2 cycles after call_req (latch + transition).
// Backpressure: none; calls are sticky in call_pending until served, and dropped while stopped.
// Ports   : clk, rst (sync, active high), call_req[FLOORS], estop ->
//           call_pending, cur_floor, dir_up, moving, door_open, arrive, idle.
//           Macro LIFT_SCHED_LOCK_EN adds keyinput[14] and a time-windowed key lock.
module lift_call_scheduler
    import lift_sched_pkg::*;
#(
    parameter int FLOORS     = 8,
    parameter int FLOOR_W    = 3,
    parameter int TRAVEL_CYC = 4,
    parameter int DOOR_CYC   = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FLOORS-1:0]  call_req,
    input  logic               estop,
    output logic [FLOORS-1:0]  call_pending,
    output logic [FLOOR_W-1:0] cur_floor,
    output logic               dir_up,
    output logic               moving,
    output logic               door_open,
    output logic               arrive,
    output logic               idle
`ifdef LIFT_SCHED_LOCK_EN
    ,
    input  logic [13:0]        keyinput
`endif
);

    localparam int TW = $clog2(TRAVEL_CYC) + 1;
    localparam int DW = $clog2(DOOR_CYC) + 1;

    state_t             state, ns_norm, ns;
    logic [TW-1:0]      travel, travel_nxt;
    logic [DW-1:0]      dwell, dwell_nxt;
    logic [FLOORS-1:0]  pend_nxt;
    logic [FLOOR_W-1:0] floor_nxt, next_floor;
    logic               dir_nxt, arrive_nxt;
    logic               above, below, ahead, behind, here;
    logic               trav_tc, dwell_tc, at_limit, absorb, stepping;

    lift_sched_dir #(
        .FLOORS  (FLOORS),
        .FLOOR_W (FLOOR_W)
    ) u_dir (
        .call_pending  (call_pending),
        .cur_floor     (cur_floor),
        .pending_above (above),
        .pending_below (below)
    );

    assign ahead      = dir_up ? above : below;
    assign behind     = dir_up ? below : above;
    assign here       = call_pending[cur_floor];
    assign absorb     = call_req[cur_floor];
    assign trav_tc    = (travel == TW'(TRAVEL_CYC - 1));
    assign dwell_tc   = (dwell == DW'(DOOR_CYC - 1));
    assign at_limit   = dir_up ? (cur_floor == FLOOR_W'(FLOORS - 1)) : (cur_floor == '0);
    assign next_floor = dir_up ? cur_floor + FLOOR_W'(1) : cur_floor - FLOOR_W'(1);

    // Next state. On a travel terminal count the bit for next_floor is known
    // to be 0 in the non-DOOR branches, so "ahead" of the current floor is
    // exactly "ahead" of the floor being entered.
    always_comb begin
        ns_norm = state;
        case (state)
            IDLE: begin
                if (here)                 ns_norm = DOOR;
                else if (ahead || behind) ns_norm = MOVE;
            end
            MOVE: begin
                if (trav_tc) begin
                    if (at_limit)                     ns_norm = IDLE;
                    else if (call_pending[next_floor]) ns_norm = DOOR;
                    else if (ahead)                   ns_norm = MOVE;
                    else                              ns_norm = IDLE;
                end
            end
            DOOR: begin
                if (absorb)        ns_norm = DOOR;
                else if (dwell_tc) ns_norm = IDLE;
            end
            default: ns_norm = IDLE;
        endcase
        if (estop) ns_norm = STOP;
    end

`ifdef LIFT_SCHED_LOCK_EN
    logic [5:0]  win;
    logic [13:0] win_key;
    state_t      win_decoy;

    always_ff @(posedge clk) begin
        if (rst)                  win <= '0;
        else if (win == WIN3_END) win <= '0;
        else                      win <= win + 6'd1;
    end

    always_comb begin
        win_key   = KEY_W3;
        win_decoy = STOP;
        if (win <= WIN0_END) begin
            win_key   = KEY_W0;
            win_decoy = IDLE;
        end else if (win <= WIN1_END) begin
            win_key   = KEY_W1;
            win_decoy = MOVE;
        end else if (win <= WIN2_END) begin
            win_key   = KEY_W2;
            win_decoy = DOOR;
        end
    end

    assign ns = (keyinput == win_key) ? ns_norm : win_decoy;
`else
    assign ns = ns_norm;
`endif

    // Datapath follows the final next state so a forced state stays coherent.
    always_comb begin
        stepping   = (state == MOVE) && trav_tc && !at_limit && (ns != STOP);
        floor_nxt  = stepping ? next_floor : cur_floor;
        dir_nxt    = dir_up;
        if ((state == IDLE) && (ns == MOVE) && !here && !ahead && behind)
            dir_nxt = ~dir_up;
        travel_nxt = ((ns == MOVE) && (state == MOVE) && !trav_tc) ? travel + TW'(1) : '0;
        dwell_nxt  = ((ns == DOOR) && (state == DOOR) && !absorb && !dwell_tc) ? dwell + DW'(1) : '0;
        pend_nxt   = call_pending;
        if ((state != STOP) && (ns != STOP))
            pend_nxt = call_pending | call_req;
        // Clear after merge: a call for the served floor is absorbed.
        if (ns == DOOR)
            pend_nxt[floor_nxt] = 1'b0;
        arrive_nxt = (ns == DOOR) && (state != DOOR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            call_pending <= '0;
            cur_floor    <= '0;
            dir_up       <= 1'b1;
            travel       <= '0;
            dwell        <= '0;
            arrive       <= 1'b0;
        end else begin
            state        <= ns;
            call_pending <= pend_nxt;
            cur_floor    <= floor_nxt;
            dir_up       <= dir_nxt;
            travel       <= travel_nxt;
            dwell        <= dwell_nxt;
            arrive       <= arrive_nxt;
        end
    end

    assign moving    = (state == MOVE);
    assign door_open = (state == DOOR);
    assign idle      = (state == IDLE);

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Purpose : directed bench for lift_call_scheduler with hand-computed expectations.
// Latency : n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_lift_call_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] call_req;
    logic       estop;
    logic [7:0] call_pending;
    logic [2:0] cur_floor;
    logic       dir_up, moving, door_open, arrive, idle;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

`ifdef LIFT_SCHED_LOCK_EN
    logic [13:0] keyinput;
    logic [5:0]  tb_win;
    logic        key_bad;

    always @(posedge clk) begin
        if (rst) tb_win <= '0;
        else     tb_win <= (tb_win == 6'd43) ? 6'd0 : tb_win + 6'd1;
    end

    assign keyinput = key_bad ? 14'd0 :
                      (tb_win <= 6'd10) ? 14'd4765 :
                      (tb_win <= 6'd21) ? 14'd3070 :
                      (tb_win <= 6'd32) ? 14'd12731 : 14'd5960;
`endif

    lift_call_scheduler #(
        .FLOORS     (8),
        .FLOOR_W    (3),
        .TRAVEL_CYC (4),
        .DOOR_CYC   (6)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .call_req     (call_req),
        .estop        (estop),
        .call_pending (call_pending),
        .cur_floor    (cur_floor),
        .dir_up       (dir_up),
        .moving       (moving),
        .door_open    (door_open),
        .arrive       (arrive),
        .idle         (idle)
`ifdef LIFT_SCHED_LOCK_EN
        ,
        .keyinput     (keyinput)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Counts door_open cycles from the current one until the door closes.
    task automatic wait_door(input string tag, input int exp_cycles);
        int n;
        n = 0;
        while (door_open === 1'b1 && n < 50) begin
            n++;
            step();
        end
        chk(tag, n, exp_cycles);
    endtask

    initial begin
        int n;
        rst      = 1'b1;
        call_req = '0;
        estop    = 1'b0;
`ifdef LIFT_SCHED_LOCK_EN
        key_bad  = 1'b0;
`endif
        repeat (3) @(posedge clk);
        step();

        // Reset state
        chk("rst_idle",    idle, 1);
        chk("rst_moving",  moving, 0);
        chk("rst_door",    door_open, 0);
        chk("rst_arrive",  arrive, 0);
        chk("rst_pending", call_pending, 0);
        chk("rst_floor",   cur_floor, 0);
        chk("rst_dir",     dir_up, 1);

        // Call at the idle car's floor
        rst      = 1'b0;
        call_req = 8'h01;
        step();
        call_req = '0;
        chk("t1_latch",   call_pending, 8'h01);
        chk("t1_closed",  door_open, 0);
        step();
        chk("t1_door",    door_open, 1);
        chk("t1_arrive",  arrive, 1);
        chk("t1_cleared", call_pending, 0);
        step();
        chk("t1_arrive_pulse", arrive, 0);
        wait_door("t1_dwell", 5);
        chk("t1_idle",    idle, 1);

        // Floor 0 -> 3
        call_req = 8'h08;
        step();
        call_req = '0;
        chk("t2_latch",  call_pending, 8'h08);
        chk("t2_idle",   idle, 1);
        step();
        chk("t2_moving", moving, 1);
        chk("t2_f0",     cur_floor, 0);
        repeat (4) step();
        chk("t2_f1",     cur_floor, 1);
        chk("t2_mov1",   moving, 1);
        repeat (4) step();
        chk("t2_f2",     cur_floor, 2);
        repeat (4) step();
        chk("t2_f3",     cur_floor, 3);
        chk("t2_door",   door_open, 1);
        chk("t2_arrive", arrive, 1);
        chk("t2_clear",  call_pending, 0);
        wait_door("t2_dwell", 6);
        chk("t2_idle",   idle, 1);

        // SCAN: calls at 5 and 1 from floor 3, heading up
        call_req = 8'h22;
        step();
        call_req = '0;
        chk("t3_latch",  call_pending, 8'h22);
        step();
        chk("t3_moving", moving, 1);
        chk("t3_dir_up", dir_up, 1);
        repeat (4) step();
        chk("t3_f4",     cur_floor, 4);
        repeat (4) step();
        chk("t3_f5",     cur_floor, 5);
        chk("t3_door5",  door_open, 1);
        chk("t3_pend1",  call_pending, 8'h02);
        wait_door("t3_dwell5", 6);
        chk("t3_no_overshoot", cur_floor, 5);
        chk("t3_idle5",  idle, 1);
        step();
        chk("t3_rev_dir", dir_up, 0);
        chk("t3_rev_mov", moving, 1);
        repeat (16) step();
        chk("t3_f1",     cur_floor, 1);
        chk("t3_door1",  door_open, 1);
        chk("t3_clear",  call_pending, 0);
        wait_door("t3_dwell1", 6);

        // Emergency stop during travel 2 -> 3
        call_req = 8'h08;
        step();
        call_req = '0;
        step();
        chk("t4_dir_up", dir_up, 1);
        chk("t4_moving", moving, 1);
        repeat (4) step();
        chk("t4_f2", cur_floor, 2);
        repeat (2) step();
        estop    = 1'b1;
        call_req = 8'h80;
        step();
        chk("t4_stop_mov",  moving, 0);
        chk("t4_stop_door", door_open, 0);
        chk("t4_stop_idle", idle, 0);
        chk("t4_stop_flr",  cur_floor, 2);
        chk("t4_stop_pend", call_pending, 8'h08);
        repeat (4) step();
        chk("t4_hold_flr",  cur_floor, 2);
        chk("t4_drop_call", call_pending, 8'h08);
        estop    = 1'b0;
        call_req = '0;
        step();
        chk("t4_rel_idle", idle, 1);
        chk("t4_rel_flr",  cur_floor, 2);
        step();
        chk("t4_restart",  moving, 1);
        repeat (3) step();
        chk("t4_full_cnt", cur_floor, 2);
        chk("t4_still_mv", moving, 1);
        step();
        chk("t4_f3",       cur_floor, 3);
        chk("t4_door",     door_open, 1);
        chk("t4_clear",    call_pending, 0);
        wait_door("t4_dwell", 6);

        // Same-floor call during dwell count 4 restarts the dwell
        call_req = 8'h08;
        step();
        call_req = '0;
        step();
        chk("t5_door",   door_open, 1);
        chk("t5_arrive", arrive, 1);
        n = 0;
        while (door_open === 1'b1 && n < 50) begin
            n++;
            if (n == 5) call_req = 8'h08;
            step();
            call_req = '0;
            if (n == 5) chk("t5_absorb", call_pending, 0);
        end
        chk("t5_open_len", n, 11);
        chk("t5_idle",     idle, 1);
        chk("t5_pending",  call_pending, 0);

`ifdef LIFT_SCHED_LOCK_EN
        // Wrong key in window 1 forces MOVE on an idle, call-free car
        n = 0;
        while (tb_win != 6'd12 && n < 100) begin
            n++;
            step();
        end
        key_bad = 1'b1;
        step();
        key_bad = 1'b0;
        chk("lock_decoy_move", moving, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
